request_scheduler: RTL and testbench

- Request bookkeeping and floor tracking between the hall/cabin buttons and the elevator control FSM.
- Latches cabin, hall-up and hall-down calls per floor.
- Tracks the current floor from the FSM's count_up/count_down strobes.
- Decodes pending requests into the direction/stop qualifiers the FSM consumes, and honours the FSM's clear commands.

---
 rtl/elevator_pkg.sv | 16 +
 rtl/floor_counter.sv | 80 ++++++++
 rtl/request_scheduler.sv | 168 ++++++++++++++++
 tb/tb_request_scheduler.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator controller and its request scheduler.
// Holds the travel-direction encoding, the default building size and the
// floor index type.
package elevator_pkg;

   localparam int unsigned DEF_FLOORS  = 8;
   localparam int unsigned DEF_FLOOR_W = 3;

   // Travel direction as driven by the control FSM; 2'b11 is treated as idle.
   localparam logic [1:0] DIR_IDLE = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DOWN = 2'b10;

   typedef logic [DEF_FLOOR_W-1:0] floor_t;

endpackage

// File: rtl/floor_counter.sv
// Current-floor tracker.
// Counts rising edges of the FSM's count_up/count_down level strobes into a
// saturating floor index. Any attempt to move past the top or bottom floor,
// or simultaneous up and down rises, leaves the floor unchanged and sets a
// sticky error flag.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   count_up   move-up strobe (level, counted on rise)
//   count_down move-down strobe (level, counted on rise)
//   floor      current floor index
//   err        sticky error, cleared only by reset
module floor_counter
   import elevator_pkg::*;
#(
   parameter int unsigned FLOORS  = DEF_FLOORS,
   parameter int unsigned FLOOR_W = DEF_FLOOR_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               count_up,
   input  logic               count_down,
   output logic [FLOOR_W-1:0] floor,
   output logic               err
);

   localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);

   logic               up_q;
   logic               down_q;
   logic               up_rise;
   logic               down_rise;
   logic [FLOOR_W-1:0] floor_q;
   logic [FLOOR_W-1:0] floor_d;
   logic               err_q;
   logic               err_d;

   assign up_rise   = count_up & ~up_q;
   assign down_rise = count_down & ~down_q;

   always_comb begin
      floor_d = floor_q;
      err_d   = err_q;
      if (up_rise && down_rise) begin
         // Contradictory move request: hold position, flag it.
         err_d = 1'b1;
      end else if (up_rise) begin
         if (floor_q == TOP_FLOOR) begin
            err_d = 1'b1;
         end else begin
            floor_d = floor_q + FLOOR_W'(1);
         end
      end else if (down_rise) begin
         if (floor_q == '0) begin
            err_d = 1'b1;
         end else begin
            floor_d = floor_q - FLOOR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         up_q    <= 1'b0;
         down_q  <= 1'b0;
         floor_q <= '0;
         err_q   <= 1'b0;
      end else begin
         up_q    <= count_up;
         down_q  <= count_down;
         floor_q <= floor_d;
         err_q   <= err_d;
      end
   end

   assign floor = floor_q;
   assign err   = err_q;

endmodule

// File: rtl/request_scheduler.sv
// Request bookkeeping between the hall/cabin buttons and the elevator FSM.
// Latches cabin, hall-up and hall-down calls per floor, tracks the current
// floor, and decodes the pending requests into the direction/stop qualifiers
// the FSM consumes. Clear commands from the FSM act on the current floor only
// and take priority over a call arriving in the same cycle.
//
// Ports:
//   clk, reset       clock (rising edge), asynchronous active-low reset
//   call_in          cabin buttons, one per floor
//   call_up          hall up buttons (top bit ignored)
//   call_down        hall down buttons (bit 0 ignored)
//   dir              FSM travel direction (00 idle, 01 up, 10 down, 11 idle)
//   count_up/down    floor-move strobes, counted on their rising edge
//   clear_*          request-clear commands applied at the current floor
//   floor            current floor
//   req_current      a request is serviceable here
//   req_up_in/down_in   cabin request above / below
//   req_up_out/down_out hall request above / below
//   req_up_max       moving up and this is the topmost pending request
//   req_down_min     moving down and this is the bottommost pending request
//   any_req          anything pending anywhere
//   err              sticky floor-counter error
module request_scheduler
   import elevator_pkg::*;
#(
   parameter int unsigned FLOORS  = DEF_FLOORS,
   parameter int unsigned FLOOR_W = DEF_FLOOR_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [FLOORS-1:0]  call_in,
   input  logic [FLOORS-1:0]  call_up,
   input  logic [FLOORS-1:0]  call_down,
   input  logic [1:0]         dir,
   input  logic               count_up,
   input  logic               count_down,
   input  logic               clear_stop,
   input  logic               clear_up,
   input  logic               clear_down,
   input  logic               clear_all_up,
   input  logic               clear_all_down,
   output logic [FLOOR_W-1:0] floor,
   output logic               req_current,
   output logic               req_up_in,
   output logic               req_down_in,
   output logic               req_up_out,
   output logic               req_down_out,
   output logic               req_up_max,
   output logic               req_down_min,
   output logic               any_req,
   output logic               err
);

   logic [FLOORS-1:0] pend_in_q;
   logic [FLOORS-1:0] pend_in_d;
   logic [FLOORS-1:0] pend_up_q;
   logic [FLOORS-1:0] pend_up_d;
   logic [FLOORS-1:0] pend_down_q;
   logic [FLOORS-1:0] pend_down_d;
   logic [FLOORS-1:0] clr_in;
   logic [FLOORS-1:0] clr_up;
   logic [FLOORS-1:0] clr_down;
   logic              clr_all_hit;
   logic              at_top;
   logic              at_bottom;

   floor_counter #(
      .FLOORS  (FLOORS),
      .FLOOR_W (FLOOR_W)
   ) u_floor_counter (
      .clk        (clk),
      .reset      (reset),
      .count_up   (count_up),
      .count_down (count_down),
      .floor      (floor),
      .err        (err)
   );

   assign at_top    = (floor == FLOOR_W'(FLOORS - 1));
   assign at_bottom = (floor == '0);

   // Stop-style clears wipe every request class at the current floor.
   assign clr_all_hit = clear_stop | clear_all_up | clear_all_down;

   always_comb begin
      clr_in   = '0;
      clr_up   = '0;
      clr_down = '0;
      for (int unsigned f = 0; f < FLOORS; f++) begin
         if (f == 32'(floor)) begin
            clr_in[f]   = clr_all_hit | clear_up | clear_down;
            clr_up[f]   = clr_all_hit | clear_up;
            clr_down[f] = clr_all_hit | clear_down;
         end
      end
   end

   always_comb begin
      pend_in_d   = (pend_in_q | call_in) & ~clr_in;
      pend_up_d   = (pend_up_q | call_up) & ~clr_up;
      pend_down_d = (pend_down_q | call_down) & ~clr_down;
      // No hall-up button on the top floor, no hall-down on the bottom.
      pend_up_d[FLOORS-1] = 1'b0;
      pend_down_d[0]      = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_in_q   <= '0;
         pend_up_q   <= '0;
         pend_down_q <= '0;
      end else begin
         pend_in_q   <= pend_in_d;
         pend_up_q   <= pend_up_d;
         pend_down_q <= pend_down_d;
      end
   end

   logic here_in;
   logic here_up;
   logic here_down;
   logic above_any;
   logic below_any;
   logic dir_up;
   logic dir_down;

   assign dir_up   = (dir == DIR_UP);
   assign dir_down = (dir == DIR_DOWN);

   always_comb begin
      here_in      = 1'b0;
      here_up      = 1'b0;
      here_down    = 1'b0;
      above_any    = 1'b0;
      below_any    = 1'b0;
      req_up_in    = 1'b0;
      req_down_in  = 1'b0;
      req_up_out   = 1'b0;
      req_down_out = 1'b0;
      any_req      = 1'b0;
      for (int unsigned f = 0; f < FLOORS; f++) begin
         any_req = any_req | pend_in_q[f] | pend_up_q[f] | pend_down_q[f];
         if (f == 32'(floor)) begin
            here_in   = pend_in_q[f];
            here_up   = pend_up_q[f];
            here_down = pend_down_q[f];
         end else if (f > 32'(floor)) begin
            req_up_in  = req_up_in | pend_in_q[f];
            req_up_out = req_up_out | pend_up_q[f] | pend_down_q[f];
            above_any  = above_any | pend_in_q[f] | pend_up_q[f] | pend_down_q[f];
         end else begin
            req_down_in  = req_down_in | pend_in_q[f];
            req_down_out = req_down_out | pend_up_q[f] | pend_down_q[f];
            below_any    = below_any | pend_in_q[f] | pend_up_q[f] | pend_down_q[f];
         end
      end
   end

   // At the end floors a hall call in the "wrong" direction is still served,
   // since the car has to turn around there anyway.
   assign req_current = here_in
                      | (here_up & (~dir_down | at_bottom))
                      | (here_down & (~dir_up | at_top));

   assign req_up_max   = dir_up & (here_in | here_up | here_down) & ~above_any;
   assign req_down_min = dir_down & (here_in | here_up | here_down) & ~below_any;

endmodule

// File: tb/tb_request_scheduler.sv
module tb_request_scheduler;
   import elevator_pkg::*;

   localparam int FLOORS  = 8;
   localparam int FLOOR_W = 3;

   logic               clk = 1'b0;
   logic               reset;
   logic [FLOORS-1:0]  call_in, call_up, call_down;
   logic [1:0]         dir;
   logic               count_up, count_down;
   logic               clear_stop, clear_up, clear_down, clear_all_up, clear_all_down;
   logic [FLOOR_W-1:0] floor;
   logic               req_current, req_up_in, req_down_in, req_up_out, req_down_out;
   logic               req_up_max, req_down_min, any_req, err;

   always #5 clk = ~clk;

   request_scheduler #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .call_in        (call_in),
      .call_up        (call_up),
      .call_down      (call_down),
      .dir            (dir),
      .count_up       (count_up),
      .count_down     (count_down),
      .clear_stop     (clear_stop),
      .clear_up       (clear_up),
      .clear_down     (clear_down),
      .clear_all_up   (clear_all_up),
      .clear_all_down (clear_all_down),
      .floor          (floor),
      .req_current    (req_current),
      .req_up_in      (req_up_in),
      .req_down_in    (req_down_in),
      .req_up_out     (req_up_out),
      .req_down_out   (req_down_out),
      .req_up_max     (req_up_max),
      .req_down_min   (req_down_min),
      .any_req        (any_req),
      .err            (err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: request sets per floor, integer floor, sticky error.
   bit m_in[FLOORS];
   bit m_up[FLOORS];
   bit m_dn[FLOORS];
   int m_floor;
   bit m_err;
   bit m_cu, m_cd;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < FLOORS; i++) begin
         m_in[i] = 0;
         m_up[i] = 0;
         m_dn[i] = 0;
      end
      m_floor = 0;
      m_err   = 0;
      m_cu    = 0;
      m_cd    = 0;
   endtask

   task automatic model_step();
      bit kill_in, kill_up, kill_dn, ru, rd;
      kill_up = clear_stop || clear_all_up || clear_all_down || clear_up;
      kill_dn = clear_stop || clear_all_up || clear_all_down || clear_down;
      kill_in = kill_up || kill_dn;
      for (int i = 0; i < FLOORS; i++) begin
         bit here;
         here    = (i == m_floor);
         m_in[i] = (m_in[i] || call_in[i]) && !(here && kill_in);
         m_up[i] = (i != FLOORS - 1) && (m_up[i] || call_up[i]) && !(here && kill_up);
         m_dn[i] = (i != 0) && (m_dn[i] || call_down[i]) && !(here && kill_dn);
      end
      ru   = count_up && !m_cu;
      rd   = count_down && !m_cd;
      m_cu = count_up;
      m_cd = count_down;
      if (ru && rd) m_err = 1;
      else if (ru) begin
         if (m_floor == FLOORS - 1) m_err = 1;
         else m_floor++;
      end else if (rd) begin
         if (m_floor == 0) m_err = 1;
         else m_floor--;
      end
   endtask

   task automatic check_all();
      bit cur, ui, di, uo, dno, any, here_any, above_any, below_any;
      bit is_up, is_dn;
      int f;
      f = m_floor;
      {ui, di, uo, dno, any, above_any, below_any} = '0;
      for (int i = 0; i < FLOORS; i++) begin
         bit p;
         p   = m_in[i] || m_up[i] || m_dn[i];
         any = any || p;
         if (i > f) begin
            ui = ui || m_in[i];
            uo = uo || m_up[i] || m_dn[i];
            above_any = above_any || p;
         end else if (i < f) begin
            di  = di || m_in[i];
            dno = dno || m_up[i] || m_dn[i];
            below_any = below_any || p;
         end
      end
      is_up    = (dir == 2'b01);
      is_dn    = (dir == 2'b10);
      here_any = m_in[f] || m_up[f] || m_dn[f];
      cur = m_in[f] || (m_up[f] && (!is_dn || f == 0))
                    || (m_dn[f] && (!is_up || f == FLOORS - 1));
      check("floor",        32'(floor),   32'(f));
      check("err",          32'(err),     32'(m_err));
      check("req_current",  32'(req_current),  32'(cur));
      check("req_up_in",    32'(req_up_in),    32'(ui));
      check("req_down_in",  32'(req_down_in),  32'(di));
      check("req_up_out",   32'(req_up_out),   32'(uo));
      check("req_down_out", 32'(req_down_out), 32'(dno));
      check("req_up_max",   32'(req_up_max),   32'(is_up && here_any && !above_any));
      check("req_down_min", 32'(req_down_min), 32'(is_dn && here_any && !below_any));
      check("any_req",      32'(any_req),      32'(any));
   endtask

   task automatic zero_inputs();
      call_in = '0; call_up = '0; call_down = '0; dir = 2'b00;
      count_up = 0; count_down = 0;
      clear_stop = 0; clear_up = 0; clear_down = 0; clear_all_up = 0; clear_all_down = 0;
   endtask

   // Called just after a falling edge with inputs already applied.
   task automatic tick();
      #1;
      check_all();
      @(posedge clk);
      if (reset) model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 0;
      zero_inputs();
      #1;
      model_reset();
      check("rst_floor", 32'(floor), 0);
      check("rst_err", 32'(err), 0);
      check("rst_any_req", 32'(any_req), 0);
      check_all();
      @(negedge clk);
      reset = 1;
   endtask

   task automatic move(input bit up, input int n);
      for (int k = 0; k < n; k++) begin
         if (up) count_up = 1; else count_down = 1;
         tick();
         count_up = 0; count_down = 0;
         tick();
      end
   endtask

   initial begin
      reset = 0;
      zero_inputs();
      model_reset();
      @(negedge clk);
      do_reset();

      // Cabin call above, ride up to it, clear it.
      call_in[3] = 1; tick(); call_in = '0;
      #1;
      check("p2_up_in", 32'(req_up_in), 1);
      check("p2_any", 32'(any_req), 1);
      check("p2_cur0", 32'(req_current), 0);
      move(1, 3);
      #1;
      check("p2_floor3", 32'(floor), 3);
      check("p2_cur3", 32'(req_current), 1);
      clear_up = 1; tick(); clear_up = 0;
      #1;
      check("p2_any_clr", 32'(any_req), 0);

      // Hall-down qualification against dir, and turnaround at the top.
      move(0, 1);
      dir = 2'b01; call_down[2] = 1; tick(); call_down = '0;
      #1;
      check("p3_cur_up", 32'(req_current), 0);
      dir = 2'b00;
      #1;
      check("p3_cur_idle", 32'(req_current), 1);
      clear_stop = 1; tick(); clear_stop = 0;
      move(1, 5);
      dir = 2'b01; call_down[7] = 1; tick(); call_down = '0;
      #1;
      check("p3_cur_top", 32'(req_current), 1);
      clear_stop = 1; tick(); clear_stop = 0; dir = 2'b00;

      // Clear wins over a held button, which re-latches on the next edge.
      move(0, 3);
      call_in[4] = 1; tick();
      clear_stop = 1; tick(); clear_stop = 0;
      #1;
      check("p4_cleared", 32'(req_current), 0);
      tick();
      #1;
      check("p4_relatched", 32'(req_current), 1);
      call_in = '0;
      clear_stop = 1; tick(); clear_stop = 0;

      // Topmost-request detection while moving up.
      move(1, 2);
      dir = 2'b01; call_in[6] = 1; call_up[2] = 1; tick();
      call_in = '0; call_up = '0;
      #1;
      check("p6_max", 32'(req_up_max), 1);
      call_in[7] = 1; tick(); call_in = '0;
      #1;
      check("p6_max_gone", 32'(req_up_max), 0);
      check("p6_up_in", 32'(req_up_in), 1);
      clear_stop = 1; tick(); clear_stop = 0; dir = 2'b00;

      // Saturation at the top floor.
      move(1, 2);
      #1;
      check("p5_sat_floor", 32'(floor), 7);
      check("p5_sat_err", 32'(err), 1);

      // Mid-operation reset at floor 5 with requests pending.
      move(0, 2);
      call_in[1] = 1; call_up[5] = 1; tick(); call_in = '0; call_up = '0;
      do_reset();

      // Simultaneous up and down rises.
      count_up = 1; count_down = 1; tick(); count_up = 0; count_down = 0;
      #1;
      check("p5_both_floor", 32'(floor), 0);
      check("p5_both_err", 32'(err), 1);
      tick();
      do_reset();

      // Randomised traffic.
      for (int c = 0; c < 500; c++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            call_in   = FLOORS'($urandom & $urandom & $urandom);
            call_up   = FLOORS'($urandom & $urandom & $urandom);
            call_down = FLOORS'($urandom & $urandom & $urandom);
            dir            = 2'($urandom_range(0, 3));
            count_up       = ($urandom_range(0, 2) == 0);
            count_down     = ($urandom_range(0, 3) == 0);
            clear_stop     = ($urandom_range(0, 5) == 0);
            clear_up       = ($urandom_range(0, 7) == 0);
            clear_down     = ($urandom_range(0, 7) == 0);
            clear_all_up   = ($urandom_range(0, 11) == 0);
            clear_all_down = ($urandom_range(0, 11) == 0);
            tick();
         end
      end
      zero_inputs();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
